// File: rtl/fdiv_ctrl_if.sv
// Core-side request/response channel of the fdiv controller.
// The master modport is the core; the slave modport is the controller.
interface fdiv_ctrl_if #(
  parameter int unsigned TAG_W = 5
) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_y;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_x1, req_x2, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_tag
  );

  modport slave (
    input  req_valid, req_x1, req_x2, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_tag
  );
endinterface

// File: rtl/fdiv_ctrl.sv
// Requester-side controller for the fixed-latency fdiv pipeline: issues operands, tracks
// in-flight ops in a tag shift register and queues results in a credit-limited FIFO.
module fdiv_ctrl #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  fdiv_ctrl_if.slave  bus,
  output logic [31:0] div_x1,
  output logic [31:0] div_x2,
  input  logic [31:0] div_y,
  output logic        busy
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned InflW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] stg_vld_q, stg_vld_d;
  logic [TAG_W-1:0]   stg_tag_q [LATENCY];
  logic [TAG_W-1:0]   stg_tag_d [LATENCY];

  logic [31:0]        fifo_y_q   [FIFO_DEPTH];
  logic [TAG_W-1:0]   fifo_tag_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CntW-1:0]    occ_q, occ_d;

  logic [31:0]        rsp_y_q, rsp_y_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

  logic [InflW-1:0]   inflight;
  logic [31:0]        credits_used;
  logic               req_ready;
  logic               rsp_valid;
  logic               fire;
  logic               push;
  logic               pop;

  assign div_x1 = bus.req_x1;
  assign div_x2 = bus.req_x2;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + InflW'(stg_vld_q[i]);
    end
  end

  // Every issued op holds a credit until its result is popped, so the FIFO can never overflow.
  assign credits_used = 32'(inflight) + 32'(occ_q);
  assign req_ready    = rstn && (credits_used < FIFO_DEPTH);
  assign rsp_valid    = rstn && (occ_q != '0);
  assign busy         = rstn && ((inflight != '0) || (occ_q != '0));

  assign fire = bus.req_valid && req_ready;
  assign push = stg_vld_q[LATENCY-1];
  assign pop  = rsp_valid && bus.rsp_ready;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_tag   = rsp_tag_q;

  always_comb begin
    stg_vld_d    = stg_vld_q;
    stg_tag_d    = stg_tag_q;
    stg_vld_d[0] = fire;
    stg_tag_d[0] = bus.req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      stg_vld_d[i] = stg_vld_q[i-1];
      stg_tag_d[i] = stg_tag_q[i-1];
    end
  end

  assign rd_nxt = rd_ptr_q + PtrW'(1);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Head registers only move when the head entry changes, so they hold the last value when empty.
  always_comb begin
    rsp_y_d   = rsp_y_q;
    rsp_tag_d = rsp_tag_q;
    if (push && ((occ_q == '0) || (pop && (occ_q == CntW'(1))))) begin
      rsp_y_d   = div_y;
      rsp_tag_d = stg_tag_q[LATENCY-1];
    end else if (pop && (occ_q > CntW'(1))) begin
      rsp_y_d   = fifo_y_q[rd_nxt];
      rsp_tag_d = fifo_tag_q[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stg_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_tag_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      rsp_y_q   <= '0;
      rsp_tag_q <= '0;
    end else begin
      stg_vld_q <= stg_vld_d;
      stg_tag_q <= stg_tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      rsp_y_q   <= rsp_y_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push) begin
      fifo_y_q[wr_ptr_q]   <= div_y;
      fifo_tag_q[wr_ptr_q] <= stg_tag_q[LATENCY-1];
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (occ_q == CntW'(FIFO_DEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rstn)
    credits_used <= FIFO_DEPTH);

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Randomised bench for fdiv_ctrl: a behavioural fdiv pipeline feeds the DUT and a
// scoreboard of issued ops predicts ready/valid/busy and every returned result.
module tb_fdiv_ctrl;
  localparam int unsigned LATENCY    = 4;
  localparam int unsigned TAG_W      = 5;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          TIMEOUT    = 200;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] div_x1;
  logic [31:0] div_x2;
  logic [31:0] div_y;
  logic        busy;

  fdiv_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fdiv_ctrl #(
    .LATENCY   (LATENCY),
    .TAG_W     (TAG_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .div_x1(div_x1),
    .div_x2(div_x2),
    .div_y (div_y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Single -> double for normals (subnormals flush to zero).
  function automatic logic [63:0] sp2dp(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'd0) return {s[31], 63'd0};
    if (s[30:23] == 8'hff) return {s[31], 11'h7ff, s[22:0], 29'd0};
    e = {3'b000, s[30:23]} + 11'd896;
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    int e;
    e = int'(d[62:52]) - 896;
    if (d[62:52] == 11'h7ff) return {d[63], 8'hff, d[51:29]};
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    return dp2sp($realtobits($bitstoreal(sp2dp(a)) / $bitstoreal(sp2dp(b))));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'(100 + $urandom_range(0, 50));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Behavioural fdiv: fixed latency, no handshake.
  logic [31:0] fdiv_pipe [LATENCY];
  always @(posedge clk) begin
    fdiv_pipe[0] <= fdiv_ref(div_x1, div_x2);
    for (int i = 1; i < LATENCY; i++) fdiv_pipe[i] <= fdiv_pipe[i-1];
  end
  assign div_y = fdiv_pipe[LATENCY-1];

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int               avail;
  } exp_t;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int               c;
  } pop_t;

  exp_t sb   [$];
  pop_t pops [$];
  int   outstanding = 0;

  // Reference: an op holds a credit from issue until popped; its result is visible
  // LATENCY+1 cycles after issue and results leave in issue order.
  always @(negedge clk) begin
    bit exp_ready;
    bit exp_valid;
    if (!rstn) begin
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      sb.delete();
      outstanding = 0;
    end else begin
      exp_ready = outstanding < int'(FIFO_DEPTH);
      exp_valid = (sb.size() != 0) && (sb[0].avail <= cyc);
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
      check("busy", 64'(busy), 64'(outstanding != 0));
      check("div_x1", 64'(div_x1), 64'(bus.req_x1));
      check("div_x2", 64'(div_x2), 64'(bus.req_x2));
      if (exp_valid) begin
        check("rsp_y", 64'(bus.rsp_y), 64'(sb[0].y));
        check("rsp_tag", 64'(bus.rsp_tag), 64'(sb[0].tag));
      end
      if (exp_valid && bus.rsp_ready) begin
        pops.push_back('{bus.rsp_y, bus.rsp_tag, cyc});
        void'(sb.pop_front());
        outstanding--;
      end
      if (bus.req_valid && exp_ready) begin
        sb.push_back('{fdiv_ref(bus.req_x1, bus.req_x2), bus.req_tag,
                       cyc + int'(LATENCY) + 1});
        outstanding++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    step(n);
  endtask

  // Presents one request and returns #1 after the edge that accepted it.
  task automatic issue(input logic [31:0] x1, input logic [31:0] x2,
                       input logic [TAG_W-1:0] tag, output int fire_cyc);
    bit fired;
    fired         = 1'b0;
    fire_cyc      = -1;
    bus.req_valid = 1'b1;
    bus.req_x1    = x1;
    bus.req_x2    = x2;
    bus.req_tag   = tag;
    for (int n = 0; n < TIMEOUT && !fired; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        fired    = 1'b1;
        fire_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    check("issue_fired", 64'(fired), 64'd1);
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    idle(12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int got;
    int fc;
    int nfire;
    int k;

    bus.req_valid = 1'b0;
    bus.req_x1    = 32'h0;
    bus.req_x2    = 32'h3F800000;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    step(3);
    rstn = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rsp_y", 64'(bus.rsp_y), 64'd0);
    check("reset_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    step(1);

    // 1: single op 6.0 / 2.0
    bus.rsp_ready = 1'b1;
    issue(32'h40C00000, 32'h40000000, TAG_W'(3), t0);
    bus.req_valid = 1'b0;
    got = -1;
    for (int n = 0; n < TIMEOUT && got < 0; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = cyc;
        check("t1_y", 64'(bus.rsp_y), 64'h40400000);
        check("t1_tag", 64'(bus.rsp_tag), 64'd3);
      end
    end
    check("t1_latency", 64'(got - t0), 64'd5);
    step(1);
    drain();

    // 2: four back-to-back 1.0 / 4.0
    pops.delete();
    for (int i = 0; i < 4; i++) issue(32'h3F800000, 32'h40800000, TAG_W'(i), fc);
    bus.req_valid = 1'b0;
    for (int n = 0; n < TIMEOUT && pops.size() < 4; n++) step(1);
    check("t2_count", 64'(pops.size()), 64'd4);
    for (int i = 0; i < pops.size(); i++) begin
      check("t2_y", 64'(pops[i].y), 64'h3E800000);
      check("t2_tag", 64'(pops[i].tag), 64'(i));
      check("t2_consecutive", 64'(pops[i].c - pops[0].c), 64'(i));
    end
    drain();

    // 3: backpressure with req_valid held
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_x1    = rand_fp();
    bus.req_x2    = rand_fp();
    nfire         = 0;
    bus.req_tag   = TAG_W'(8);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.req_ready) nfire++;
      @(posedge clk);
      #1;
      bus.req_tag = TAG_W'(8 + nfire);
    end
    check("t3_fires", 64'(nfire), 64'd4);
    @(negedge clk);
    check("t3_ready_low", 64'(bus.req_ready), 64'd0);
    step(1);
    idle(6);
    pops.delete();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_at_pop", 64'(bus.rsp_valid), 64'd1);
    check("t3_ready_at_pop", 64'(bus.req_ready), 64'd0);
    step(1);
    @(negedge clk);
    check("t3_ready_after_pop", 64'(bus.req_ready), 64'd1);
    step(1);
    for (int n = 0; n < TIMEOUT && pops.size() < 4; n++) step(1);
    check("t3_count", 64'(pops.size()), 64'd4);
    if (pops.size() == 4) check("t3_one_per_cycle", 64'(pops[3].c - pops[0].c), 64'd3);
    drain();

    // 6: simultaneous push and pop with three entries queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(rand_fp(), rand_fp(), TAG_W'(20 + i), fc);
    idle(6);
    issue(rand_fp(), rand_fp(), TAG_W'(23), fc);
    idle(3);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_head", 64'(bus.rsp_tag), 64'd20);
    step(1);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("t6_valid", 64'(bus.rsp_valid), 64'd1);
    check("t6_next_head", 64'(bus.rsp_tag), 64'd21);
    check("t6_credit", 64'(bus.req_ready), 64'd1);
    step(1);
    pops.delete();
    bus.rsp_ready = 1'b1;
    idle(10);
    check("t6_remaining", 64'(pops.size()), 64'd3);
    for (int i = 0; i < pops.size(); i++) check("t6_order", 64'(pops[i].tag), 64'(21 + i));
    drain();

    // 4: 20 ops, random issue gaps and random rsp_ready
    pops.delete();
    k = 0;
    for (int n = 0; n < 1000 && pops.size() < 20; n++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      if (k < 20 && $urandom_range(0, 3) != 0) begin
        bus.req_valid = 1'b1;
        bus.req_x1    = rand_fp();
        bus.req_x2    = rand_fp();
        bus.req_tag   = TAG_W'(k);
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) k++;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check("t4_count", 64'(pops.size()), 64'd20);
    for (int i = 0; i < pops.size(); i++) check("t4_order", 64'(pops[i].tag), 64'(i));
    drain();

    // 5: reset with one result queued and two ops in flight
    bus.rsp_ready = 1'b0;
    issue(rand_fp(), rand_fp(), TAG_W'(1), fc);
    idle(2);
    issue(rand_fp(), rand_fp(), TAG_W'(2), fc);
    issue(rand_fp(), rand_fp(), TAG_W'(3), fc);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_valid", 64'(bus.rsp_valid), 64'd1);
    check("t5_pre_busy", 64'(busy), 64'd1);
    step(1);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("t5_no_stale_valid", 64'(bus.rsp_valid), 64'd0);
      check("t5_not_busy", 64'(busy), 64'd0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
